txn_arbiter: RTL
================

Name: txn_arbiter

Overview:
Round-robin arbiter that shares one slave's separate write and read channels among NUM_MASTERS requesters.
- Each master posts one transaction at a time (write or read).
- The arbiter grants one master, drives the matching slave channel with a valid/ready handshake, and returns resp/rdata to the granted master.
- A timeout turns a missing slave ready (e.g. out-of-range address) into an error response.
- It sits between the transaction managers and a slave instance.

Parameters:
NUM_MASTERS, 4, number of requesters (2..8)
ADDR_W, 8, address width
DATA_W, 32, data width
TIMEOUT, 16, max cycles waiting for slave ready before error (>=6)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
m_valid  input  NUM_MASTERS  per-master request; held until m_ready
m_write  input  NUM_MASTERS  per-master 1=write, 0=read
m_addr  input  NUM_MASTERS*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W]
m_wdata  input  NUM_MASTERS*DATA_W  per-master write data, same packing
m_ready  output  NUM_MASTERS  one-cycle completion pulse to granted master
m_resp  output  2  response for completing master (00 ok, 11 timeout)
m_rdata  output  DATA_W  read data for completing master
grant_id  output  $clog2(NUM_MASTERS)  index of current/last grant
busy  output  1  high in ISSUE and DONE
w_valid, w_addr, w_data  output  1/ADDR_W/DATA_W  slave write channel
w_ready, w_resp  input  1/2  slave write channel
r_valid, r_addr  output  1/ADDR_W  slave read channel
r_ready, r_resp, r_data  input  1/2/DATA_W  slave read channel

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; state=IDLE; priority pointer ptr=NUM_MASTERS-1, so master 0 wins first; timeout counter 0.
  - Reset mid-transaction drops w_valid/r_valid immediately and no m_ready is issued.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If any m_valid is set, pick the winner by searching from ptr+1 upward, wrapping modulo NUM_MASTERS.
  - On that edge: latch the winner's write/addr/wdata into holding regs, set grant_id, drive w_valid=1 (write) or r_valid=1 (read) with addr/data from the holding regs, clear counter, go to ISSUE.
  - If no m_valid is set, stay in IDLE.
- ISSUE:
  - Hold valid and channel addr/data stable; counter increments each cycle.
  - Only the channel matching the latched direction is driven; the other channel's valid stays 0.
  - Ready sampled high on the active channel: deassert valid; capture resp (and r_data for reads; m_rdata=0 for writes); go to DONE.
  - Counter reaches TIMEOUT-1 with no ready: deassert valid; resp=11, rdata=0; go to DONE.
  - Ready and timeout on the same edge: ready wins.
- DONE (exactly one cycle):
  - m_ready[grant_id]=1 with m_resp/m_rdata valid; all other m_ready bits 0.
  - ptr<=grant_id; return to IDLE.
  - m_resp/m_rdata hold their values until the next DONE.
- Minimum gap: no new issue earlier than the cycle after DONE. The slave therefore always sees valid low for at least one edge between transactions, which prevents a double accept.
- Fixed overhead is 1 cycle to issue plus 1 DONE cycle, on top of slave latency (1-4 cycles) and one sampling edge.
- Request changes after grant: m_valid, m_addr and m_wdata changes are ignored; the latched copy is used. A master dropping m_valid mid-transaction still receives m_ready.
- Master receiving m_ready: if it keeps m_valid high the next cycle, that is a new request and is arbitrated normally (lowest priority now).
- Fairness: with all masters requesting continuously, grants rotate 0,1,2,...,N-1,0. Each master waits at most N-1 transactions.

Test Plan:
- Reset: assert rst mid-ISSUE -> w_valid/r_valid/m_ready/busy drop to 0 asynchronously; after release, first grant with m_valid=4'b1111 goes to master 0.
- Single write then read: master 2 writes addr 8'h10 data 32'hDEADBEEF, then reads 8'h10 -> write m_resp=00; read m_rdata=32'hDEADBEEF, m_resp=00; only m_ready[2] pulses.
- Round robin: all 4 masters request writes continuously -> grant_id sequence 0,1,2,3,0; exactly one m_ready pulse per transaction.
- Timeout: master 1 reads addr 8'hF0, outside BASE_ADDR=0/RANGE=3F -> r_valid high exactly 16 cycles, then m_resp=11, m_rdata=0; next grant proceeds normally.
- Channel exclusivity: mixed write (master 0) and read (master 3) pending -> w_valid and r_valid never high together; read returns prior written value.
- Slave latency sweep 1..4: check m_ready arrives between 3 and 7 cycles after the grant edge, and w_valid is low for at least one cycle between back-to-back issues.

Source files
------------

// File: rtl/txn_arbiter.sv
// Round-robin arbiter sharing one slave's write and read channels among NUM_MASTERS requesters.
// A slave that never raises ready is converted into a timeout error response (resp 11).
module txn_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_MASTERS-1:0]           m_valid,
  input  logic [NUM_MASTERS-1:0]           m_write,
  input  logic [NUM_MASTERS*ADDR_W-1:0]    m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]    m_wdata,
  output logic [NUM_MASTERS-1:0]           m_ready,
  output logic [1:0]                       m_resp,
  output logic [DATA_W-1:0]                m_rdata,
  output logic [$clog2(NUM_MASTERS)-1:0]   grant_id,
  output logic                             busy,
  output logic                             w_valid,
  output logic [ADDR_W-1:0]                w_addr,
  output logic [DATA_W-1:0]                w_data,
  input  logic                             w_ready,
  input  logic [1:0]                       w_resp,
  output logic                             r_valid,
  output logic [ADDR_W-1:0]                r_addr,
  input  logic                             r_ready,
  input  logic [1:0]                       r_resp,
  input  logic [DATA_W-1:0]                r_data
);

  localparam int IDW  = $clog2(NUM_MASTERS);
  localparam int CNTW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  state_t                   state_r, state_s;
  logic [IDW-1:0]           ptr_r, ptr_s, grant_r, grant_s, win_s;
  logic                     wr_r, wr_s, sel_wr_s;
  logic [ADDR_W-1:0]        addr_r, addr_s, sel_addr_s;
  logic [DATA_W-1:0]        data_r, data_s, sel_data_s;
  logic [CNTW-1:0]          cnt_r, cnt_s;
  logic                     w_valid_r, w_valid_s, r_valid_r, r_valid_s;
  logic [NUM_MASTERS-1:0]   m_ready_r, m_ready_s;
  logic [1:0]               m_resp_r, m_resp_s;
  logic [DATA_W-1:0]        m_rdata_r, m_rdata_s;
  logic                     busy_r, busy_s;
  logic                     accept_s, timeout_s;

  // First requester strictly after ptr, wrapping; the last granted master has lowest priority.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                             input logic [IDW-1:0] ptr);
    logic [IDW-1:0]         pick;
    logic                   found, hit;
    logic [NUM_MASTERS-1:0] req_rot;
    int                     idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx     = (int'(ptr) + k) % NUM_MASTERS;
      req_rot = req >> idx;
      hit     = !found && req_rot[0];
      pick    = hit ? IDW'(idx) : pick;
      found   = found | hit;
    end
    return pick;
  endfunction

  // Winner selection and handshake conditions
  always_comb begin
    win_s      = rr_pick(m_valid, ptr_r);
    sel_wr_s   = m_write[win_s];
    sel_addr_s = m_addr[win_s*ADDR_W +: ADDR_W];
    sel_data_s = m_wdata[win_s*DATA_W +: DATA_W];
    accept_s   = wr_r ? (w_valid_r && w_ready) : (r_valid_r && r_ready);
    timeout_s  = (cnt_r == CNTW'(TIMEOUT - 1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (|m_valid) state_s = ISSUE; else state_s = IDLE;
      ISSUE:   if (accept_s || timeout_s) state_s = DONE; else state_s = ISSUE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the holding registers and registered outputs
  always_comb begin
    ptr_s     = ptr_r;
    grant_s   = grant_r;
    wr_s      = wr_r;
    addr_s    = addr_r;
    data_s    = data_r;
    cnt_s     = cnt_r;
    w_valid_s = w_valid_r;
    r_valid_s = r_valid_r;
    m_ready_s = '0;
    m_resp_s  = m_resp_r;
    m_rdata_s = m_rdata_r;
    busy_s    = busy_r;
    case (state_r)
      IDLE: begin
        if (|m_valid) begin
          grant_s   = win_s;
          wr_s      = sel_wr_s;
          addr_s    = sel_addr_s;
          data_s    = sel_data_s;
          cnt_s     = '0;
          w_valid_s = sel_wr_s;
          r_valid_s = ~sel_wr_s;
          busy_s    = 1'b1;
        end else begin
          busy_s    = 1'b0;
        end
      end
      ISSUE: begin
        cnt_s = cnt_r + CNTW'(1);
        // Ready is checked before timeout so a last-cycle accept still completes normally.
        if (accept_s) begin
          w_valid_s = 1'b0;
          r_valid_s = 1'b0;
          m_ready_s = NUM_MASTERS'(1) << grant_r;
          m_resp_s  = wr_r ? w_resp : r_resp;
          m_rdata_s = wr_r ? '0 : r_data;
        end else if (timeout_s) begin
          w_valid_s = 1'b0;
          r_valid_s = 1'b0;
          m_ready_s = NUM_MASTERS'(1) << grant_r;
          m_resp_s  = 2'b11;
          m_rdata_s = '0;
        end else begin
          w_valid_s = w_valid_r;
          r_valid_s = r_valid_r;
        end
      end
      DONE: begin
        ptr_s  = grant_r;
        busy_s = 1'b0;
      end
      default: begin
        w_valid_s = 1'b0;
        r_valid_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r     <= IDW'(NUM_MASTERS - 1);
      grant_r   <= '0;
      wr_r      <= 1'b0;
      addr_r    <= '0;
      data_r    <= '0;
      cnt_r     <= '0;
      w_valid_r <= 1'b0;
      r_valid_r <= 1'b0;
      m_ready_r <= '0;
      m_resp_r  <= 2'b00;
      m_rdata_r <= '0;
      busy_r    <= 1'b0;
    end else begin
      ptr_r     <= ptr_s;
      grant_r   <= grant_s;
      wr_r      <= wr_s;
      addr_r    <= addr_s;
      data_r    <= data_s;
      cnt_r     <= cnt_s;
      w_valid_r <= w_valid_s;
      r_valid_r <= r_valid_s;
      m_ready_r <= m_ready_s;
      m_resp_r  <= m_resp_s;
      m_rdata_r <= m_rdata_s;
      busy_r    <= busy_s;
    end
  end

  assign m_ready  = m_ready_r;
  assign m_resp   = m_resp_r;
  assign m_rdata  = m_rdata_r;
  assign grant_id = grant_r;
  assign busy     = busy_r;
  assign w_valid  = w_valid_r;
  assign w_addr   = addr_r;
  assign w_data   = data_r;
  assign r_valid  = r_valid_r;
  assign r_addr   = addr_r;

endmodule
